// File: rtl/decomp_pkg.sv
// Shared code table for the decompressor: code types, prefixes, lengths and
// the prefix decode function used by both word slots of the length parser.
package decomp_pkg;

  localparam int CACHE_LINE     = 128;
  localparam int WIN_W          = 2 * CACHE_LINE;
  localparam int PAIRS_PER_LINE = 8;
  localparam int IDX_W          = 4;

  typedef enum logic [2:0] {
    ZZZZ = 3'd0,
    XXXX = 3'd1,
    MMMM = 3'd2,
    MMXX = 3'd3,
    ZZZX = 3'd4,
    MMMX = 3'd5
  } code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  localparam logic [1:0] PFX_ZZZZ    = 2'b00;
  localparam logic [1:0] PFX_XXXX    = 2'b01;
  localparam logic [1:0] PFX_MMMM    = 2'b10;
  localparam logic [3:0] PFX_MMXX    = 4'b1100;
  localparam logic [3:0] PFX_ZZZX    = 4'b1101;
  localparam logic [3:0] PFX_MMMX    = 4'b1110;

  localparam logic [5:0] LEN_ZZZZ    = 6'd2;
  localparam logic [5:0] LEN_XXXX    = 6'd34;
  localparam logic [5:0] LEN_MMMM    = 6'(2 + IDX_W);
  localparam logic [5:0] LEN_MMXX    = 6'(4 + IDX_W + 16);
  localparam logic [5:0] LEN_ZZZX    = 6'd12;
  localparam logic [5:0] LEN_MMMX    = 6'(4 + IDX_W + 8);
  localparam logic [5:0] LEN_ILLEGAL = 6'd4;

  typedef struct packed {
    code_e      enc;
    logic [5:0] len;
    logic       illegal;
  } prefix_info_t;

  function automatic prefix_info_t decode_prefix(input logic [3:0] p);
    prefix_info_t r;
    r.enc     = ZZZZ;
    r.len     = LEN_ZZZZ;
    r.illegal = 1'b0;
    if (p[3:2] == PFX_ZZZZ) begin
      r.enc = ZZZZ;
      r.len = LEN_ZZZZ;
    end else if (p[3:2] == PFX_XXXX) begin
      r.enc = XXXX;
      r.len = LEN_XXXX;
    end else if (p[3:2] == PFX_MMMM) begin
      r.enc = MMMM;
      r.len = LEN_MMMM;
    end else if (p == PFX_MMXX) begin
      r.enc = MMXX;
      r.len = LEN_MMXX;
    end else if (p == PFX_ZZZX) begin
      r.enc = ZZZX;
      r.len = LEN_ZZZX;
    end else if (p == PFX_MMMX) begin
      r.enc = MMMX;
      r.len = LEN_MMMX;
    end else begin
      r.len     = LEN_ILLEGAL;
      r.illegal = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prefix_decoder.sv
// Decodes one word starting i_offset bits below the window MSB: code type,
// total length and the right-aligned payload that follows the prefix.
module prefix_decoder
  import decomp_pkg::*;
(
  input  logic [WIN_W-1:0] i_window,
  input  logic [5:0]       i_offset,
  output code_e            o_enc,
  output logic [5:0]       o_len,
  output logic             o_illegal,
  output logic [31:0]      o_payload
);

  logic [3:0]   prefix;
  prefix_info_t info;
  logic [2:0]   pre_len;
  logic [5:0]   pay_len;
  logic [6:0]   pay_start;
  logic [31:0]  raw;

  always_comb begin
    prefix    = 4'((i_window << i_offset) >> (WIN_W - 4));
    info      = decode_prefix(prefix);
    pre_len   = (prefix[3] & prefix[2]) ? 3'd4 : 3'd2;
    pay_len   = info.len - 6'(pre_len);
    pay_start = {1'b0, i_offset} + {4'd0, pre_len};
    // Top 32 bits after the prefix, then drop whatever belongs to the next word.
    raw       = 32'((i_window << pay_start) >> (WIN_W - 32));
    o_enc     = info.enc;
    o_len     = info.len;
    o_illegal = info.illegal;
    o_payload = (pay_len == 6'd0) ? 32'd0 : (raw >> (6'd32 - pay_len));
  end

endmodule

// File: rtl/length_parser.sv
// Bit-window front end of the decompressor: buffers 128-bit chunks and
// emits two decoded words per fire, dropping line-end padding after pair 7.
//
// state    | meaning
// ST_IDLE  | window empty (count == 0)
// ST_RUN   | window holds bits, pairs may fire
// ST_ERROR | illegal prefix decoded, frozen until reset
module length_parser
  import decomp_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [CACHE_LINE-1:0] i_comp_data,
  input  logic                  i_comp_valid,
  output logic                  o_comp_ready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2:0]            o_encoded1,
  output logic [2:0]            o_encoded2,
  output logic [5:0]            o_length1,
  output logic [5:0]            o_length2,
  output logic [6:0]            o_total_length,
  output logic [31:0]           o_payload1,
  output logic [31:0]           o_payload2,
  output logic                  o_last_pair,
  output logic                  o_error
);

  logic [WIN_W-1:0] window_q, window_d;
  logic [8:0]       count_q, count_d;
  logic [6:0]       line_off_q, line_off_d;
  logic [2:0]       pair_cnt_q, pair_cnt_d;
  state_e           state_q, state_d;

  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             last_pair_q, last_pair_d;
  logic [2:0]       enc1_q, enc1_d, enc2_q, enc2_d;
  logic [5:0]       len1_q, len1_d, len2_q, len2_d;
  logic [6:0]       total_q, total_d;
  logic [31:0]      pay1_q, pay1_d, pay2_q, pay2_d;

  code_e            enc1, enc2;
  logic [5:0]       len1, len2;
  logic             ill1, ill2;
  logic [31:0]      pay1, pay2;

  logic [6:0]       total;
  logic [8:0]       need2;
  logic             long2;
  logic             last;
  logic [6:0]       pad;
  logic [7:0]       shift;
  logic             fire;
  logic             accept;
  logic [WIN_W-1:0] win_s;
  logic [8:0]       count_s;

  prefix_decoder u_word1 (
    .i_window  (window_q),
    .i_offset  (6'd0),
    .o_enc     (enc1),
    .o_len     (len1),
    .o_illegal (ill1),
    .o_payload (pay1)
  );

  prefix_decoder u_word2 (
    .i_window  (window_q),
    .i_offset  (len1),
    .o_enc     (enc2),
    .o_len     (len2),
    .o_illegal (ill2),
    .o_payload (pay2)
  );

  assign o_comp_ready   = (state_q != ST_ERROR) && (count_q <= 9'd128);
  assign o_valid        = valid_q;
  assign o_error        = error_q;
  assign o_last_pair    = last_pair_q;
  assign o_encoded1     = enc1_q;
  assign o_encoded2     = enc2_q;
  assign o_length1      = len1_q;
  assign o_length2      = len2_q;
  assign o_total_length = total_q;
  assign o_payload1     = pay1_q;
  assign o_payload2     = pay2_q;

  always_comb begin
    total  = {1'b0, len1} + {1'b0, len2};
    // Word2 needs its full prefix present before its length can be trusted.
    long2  = ill2 || (enc2 == MMXX) || (enc2 == ZZZX) || (enc2 == MMMX);
    need2  = 9'(len1) + (long2 ? 9'd4 : 9'd2);
    last   = (pair_cnt_q == 3'(PAIRS_PER_LINE - 1));
    pad    = last ? 7'(7'd0 - line_off_q - total) : 7'd0;
    shift  = {1'b0, total} + {1'b0, pad};
    fire   = (state_q == ST_RUN) && (count_q >= need2) &&
             (count_q >= 9'(total)) && (!valid_q || i_ready);
    accept = i_comp_valid && o_comp_ready;

    window_d    = window_q;
    count_d     = count_q;
    line_off_d  = line_off_q;
    pair_cnt_d  = pair_cnt_q;
    valid_d     = valid_q;
    error_d     = error_q;
    last_pair_d = last_pair_q;
    enc1_d      = enc1_q;
    enc2_d      = enc2_q;
    len1_d      = len1_q;
    len2_d      = len2_q;
    total_d     = total_q;
    pay1_d      = pay1_q;
    pay2_d      = pay2_q;
    win_s       = window_q;
    count_s     = count_q;

    if (fire && (ill1 || ill2)) begin
      error_d = 1'b1;
      valid_d = 1'b0;
    end else if (fire) begin
      valid_d     = 1'b1;
      enc1_d      = enc1;
      enc2_d      = enc2;
      len1_d      = len1;
      len2_d      = len2;
      total_d     = total;
      pay1_d      = pay1;
      pay2_d      = pay2;
      last_pair_d = last;
      line_off_d  = last ? 7'd0 : line_off_q + total;
      pair_cnt_d  = last ? 3'd0 : pair_cnt_q + 3'd1;
      win_s       = window_q << shift;
      count_s     = (count_q >= 9'(shift)) ? count_q - 9'(shift) : 9'd0;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end

    window_d = win_s;
    count_d  = count_s;
    if (accept) begin
      window_d = win_s | ({i_comp_data, {CACHE_LINE{1'b0}}} >> count_s);
      count_d  = count_s + 9'd128;
    end

    if (error_d)            state_d = ST_ERROR;
    else if (count_d == '0) state_d = ST_IDLE;
    else                    state_d = ST_RUN;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      window_q    <= '0;
      count_q     <= '0;
      line_off_q  <= '0;
      pair_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      last_pair_q <= 1'b0;
      enc1_q      <= '0;
      enc2_q      <= '0;
      len1_q      <= '0;
      len2_q      <= '0;
      total_q     <= '0;
      pay1_q      <= '0;
      pay2_q      <= '0;
    end else begin
      window_q    <= window_d;
      count_q     <= count_d;
      line_off_q  <= line_off_d;
      pair_cnt_q  <= pair_cnt_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      last_pair_q <= last_pair_d;
      enc1_q      <= enc1_d;
      enc2_q      <= enc2_d;
      len1_q      <= len1_d;
      len2_q      <= len2_d;
      total_q     <= total_d;
      pay1_q      <= pay1_d;
      pay2_q      <= pay2_d;
    end
  end

endmodule

// File: tb/tb_length_parser.sv
// Scoreboard bench for length_parser: builds padded lines bit by bit from its
// own code table, queues the expected pairs and checks them as they drain.
module tb_length_parser;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic [127:0] i_comp_data;
  logic         i_comp_valid;
  logic         o_comp_ready;
  logic         o_valid;
  logic         i_ready;
  logic [2:0]   o_encoded1, o_encoded2;
  logic [5:0]   o_length1, o_length2;
  logic [6:0]   o_total_length;
  logic [31:0]  o_payload1, o_payload2;
  logic         o_last_pair;
  logic         o_error;

  always #5 i_clk = ~i_clk;

  length_parser dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_comp_data    (i_comp_data),
    .i_comp_valid   (i_comp_valid),
    .o_comp_ready   (o_comp_ready),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_encoded1     (o_encoded1),
    .o_encoded2     (o_encoded2),
    .o_length1      (o_length1),
    .o_length2      (o_length2),
    .o_total_length (o_total_length),
    .o_payload1     (o_payload1),
    .o_payload2     (o_payload2),
    .o_last_pair    (o_last_pair),
    .o_error        (o_error)
  );

  typedef struct packed {
    logic [2:0]  enc1;
    logic [2:0]  enc2;
    logic [5:0]  len1;
    logic [5:0]  len2;
    logic [6:0]  total;
    logic [31:0] pay1;
    logic [31:0] pay2;
    logic        last;
  } pair_t;

  typedef struct packed {
    logic [2:0]  enc;
    logic [5:0]  len;
    logic [31:0] pay;
  } word_t;

  pair_t sbq[$];
  word_t wq[$];
  bit    bitq[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void code_of(input int enc, output logic [3:0] pfx,
                                  output int pw, output int plw);
    case (enc)
      0:       begin pfx = 4'b0000; pw = 2; plw = 0;  end
      1:       begin pfx = 4'b0001; pw = 2; plw = 32; end
      2:       begin pfx = 4'b0010; pw = 2; plw = 4;  end
      3:       begin pfx = 4'b1100; pw = 4; plw = 20; end
      4:       begin pfx = 4'b1101; pw = 4; plw = 8;  end
      default: begin pfx = 4'b1110; pw = 4; plw = 12; end
    endcase
  endfunction

  task automatic put_word(input int enc, input logic [31:0] pay);
    logic [3:0] pfx;
    int pw, plw;
    word_t w;
    code_of(enc, pfx, pw, plw);
    for (int i = pw - 1; i >= 0; i--) bitq.push_back(pfx[i]);
    for (int i = plw - 1; i >= 0; i--) bitq.push_back(pay[i]);
    w.enc = 3'(enc);
    w.len = 6'(pw + plw);
    w.pay = '0;
    for (int i = 0; i < plw; i++) w.pay[i] = pay[i];
    wq.push_back(w);
  endtask

  task automatic end_line();
    pair_t p;
    for (int k = 0; k < 8; k++) begin
      p.enc1  = wq[2*k].enc;
      p.enc2  = wq[2*k+1].enc;
      p.len1  = wq[2*k].len;
      p.len2  = wq[2*k+1].len;
      p.total = 7'(wq[2*k].len) + 7'(wq[2*k+1].len);
      p.pay1  = wq[2*k].pay;
      p.pay2  = wq[2*k+1].pay;
      p.last  = (k == 7);
      sbq.push_back(p);
    end
    while (bitq.size() % 128 != 0) bitq.push_back(1'b0);
    wq.delete();
  endtask

  task automatic drive_chunk(input logic [127:0] c);
    bit ok;
    ok = 0;
    @(posedge i_clk); #1;
    i_comp_data  = c;
    i_comp_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge i_clk);
      if (o_comp_ready) ok = 1;
      @(posedge i_clk); #1;
    end
    i_comp_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_one();
    logic [127:0] c;
    for (int i = 0; i < 128; i++) c[127-i] = bitq.pop_front();
    drive_chunk(c);
  endtask

  task automatic wait_sb(input int n);
    for (int t = 0; t < 1000 && sbq.size() > n; t++) @(negedge i_clk);
    if (sbq.size() > n) chk("sb_timeout", 128'(sbq.size()), 128'(n));
  endtask

  task automatic do_reset();
    @(posedge i_clk); #3;
    i_reset = 1'b1;
    #1;
    chk("rst_valid",   o_valid, 0);
    chk("rst_error",   o_error, 0);
    chk("rst_last",    o_last_pair, 0);
    chk("rst_enc1",    o_encoded1, 0);
    chk("rst_enc2",    o_encoded2, 0);
    chk("rst_len1",    o_length1, 0);
    chk("rst_len2",    o_length2, 0);
    chk("rst_total",   o_total_length, 0);
    chk("rst_pay1",    o_payload1, 0);
    chk("rst_pay2",    o_payload2, 0);
    chk("rst_ready",   o_comp_ready, 1);
    sbq.delete();
    wq.delete();
    bitq.delete();
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  always @(negedge i_clk) begin : mon
    pair_t e;
    if (!i_reset && o_valid && i_ready) begin
      if (sbq.size() == 0) chk("unexpected_pair", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("enc1",  o_encoded1, e.enc1);
        chk("enc2",  o_encoded2, e.enc2);
        chk("len1",  o_length1, e.len1);
        chk("len2",  o_length2, e.len2);
        chk("total", o_total_length, e.total);
        chk("pay1",  o_payload1, e.pay1);
        chk("pay2",  o_payload2, e.pay2);
        chk("last",  o_last_pair, e.last);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] c;
    i_reset      = 1'b1;
    i_comp_data  = '0;
    i_comp_valid = 1'b0;
    i_ready      = 1'b1;
    repeat (2) @(posedge i_clk);
    do_reset();

    // all-zzzz line: 8 pairs of total 4, last pair drops 96 pad bits
    for (int i = 0; i < 16; i++) put_word(0, 32'h0);
    end_line();
    send_one();
    wait_sb(0);
    repeat (3) @(negedge i_clk);
    chk("ready_idle", o_comp_ready, 1);
    chk("valid_idle", o_valid, 0);

    // xxxx + mmmm pair followed by zero padding words
    put_word(1, 32'hDEADBEEF);
    put_word(2, 32'h5);
    for (int i = 0; i < 14; i++) put_word(0, 32'h0);
    end_line();
    send_one();
    wait_sb(0);

    // four xxxx words straddle the chunk boundary
    put_word(1, 32'h12345678);
    put_word(1, 32'h9ABCDEF0);
    put_word(1, 32'h0F1E2D3C);
    put_word(1, 32'hA5A55A5A);
    for (int i = 0; i < 12; i++) put_word(0, 32'h0);
    end_line();
    send_one();
    wait_sb(7);
    repeat (5) @(negedge i_clk);
    chk("straddle_hold", o_valid, 0);
    send_one();
    wait_sb(0);

    // downstream stall while a second line fills the window
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    put_word(3, 32'hABCDE);
    put_word(4, 32'h5A);
    put_word(5, 32'h123);
    put_word(2, 32'h9);
    for (int i = 0; i < 12; i++) put_word(0, 32'h0);
    end_line();
    send_one();
    for (int i = 0; i < 16; i++) put_word(0, 32'h0);
    end_line();
    send_one();
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("stall_valid", o_valid, 1);
      chk("stall_enc1",  o_encoded1, sbq[0].enc1);
      chk("stall_pay1",  o_payload1, sbq[0].pay1);
      chk("stall_total", o_total_length, sbq[0].total);
    end
    chk("stall_ready_low", o_comp_ready, 0);
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    wait_sb(0);

    // illegal prefix in word2: 00 then 1111
    c = 128'h3C;
    c = c << 120;
    drive_chunk(c);
    repeat (4) @(negedge i_clk);
    chk("err_flag",  o_error, 1);
    chk("err_valid", o_valid, 0);
    chk("err_ready", o_comp_ready, 0);
    @(posedge i_clk); #1;
    i_comp_data  = '0;
    i_comp_valid = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("err_ready_hold", o_comp_ready, 0);
    chk("err_sticky",     o_error, 1);
    i_comp_valid = 1'b0;
    do_reset();

    // reset mid-line with 60 bits left in the window
    put_word(1, 32'hCAFEF00D);
    put_word(1, 32'h01234567);
    put_word(1, 32'h89ABCDEF);
    put_word(1, 32'hFEDCBA98);
    for (int i = 0; i < 12; i++) put_word(0, 32'h0);
    end_line();
    send_one();
    wait_sb(7);
    repeat (2) @(negedge i_clk);
    do_reset();

    put_word(1, 32'hDEADBEEF);
    put_word(2, 32'h5);
    for (int i = 0; i < 14; i++) put_word(0, 32'h0);
    end_line();
    send_one();
    wait_sb(0);
    repeat (2) @(negedge i_clk);
    chk("final_error", o_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
